// File: rtl/mem_stage_if.sv
// Word-wide data-memory request/ready bus between the MEM stage and data memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V core: issues data-memory requests, stalls on
// wait states, flags misaligned/timed-out accesses and writes the MEM/WB register.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hazard_flush,
  input  logic        EX_MEM_enable_out,
  input  logic [31:0] EX_MEM_PC,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_MemToReg,
  input  logic        EX_MEM_RegWrite,
  mem_stage_if.master dmem,
  output logic        mem_stall_req,
  output logic [31:0] MEM_WB_PC,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [31:0] MEM_WB_ReadData,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_MemToReg,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_enable_out,
  output logic        MEM_misaligned,
  output logic        MEM_bus_error,
  output logic [31:0] MEM_error_addr
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic       TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        squash_q, squash_d;
  logic [31:0] h_pc_q, h_pc_d, h_alu_q, h_alu_d;
  logic [4:0]  h_rd_q, h_rd_d;
  logic        h_m2r_q, h_m2r_d, h_rw_q, h_rw_d;
  logic [31:0] wb_pc_q, wb_pc_d, wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_m2r_q, wb_m2r_d, wb_rw_q, wb_rw_d, wb_en_q, wb_en_d;
  logic        mis_q, mis_d, berr_q, berr_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic mem_op, misaligned, aligned_op, done, abort, squash;

  assign mem_op     = EX_MEM_enable_out & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign misaligned = mem_op & (|EX_MEM_ALUResult[1:0]);
  assign aligned_op = mem_op & ~misaligned;
  assign done       = (state_q == BUSY) & dmem.dmem_ready;
  assign abort      = (state_q == BUSY) & ~dmem.dmem_ready & TO_EN & (cnt_q == TO_LAST);
  assign squash     = squash_q | hazard_flush;

  assign mem_stall_req = ((state_q == IDLE) & aligned_op & ~hazard_flush) |
                         ((state_q == BUSY) & ~dmem.dmem_ready & ~abort);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!hazard_flush && aligned_op) state_d = BUSY;
      BUSY: if (done || abort)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;  we_d = we_q;  addr_d = addr_q;  wdata_d = wdata_q;
    wstrb_d = wstrb_q;  cnt_d = cnt_q;  squash_d = squash_q;
    h_pc_d = h_pc_q;  h_alu_d = h_alu_q;  h_rd_d = h_rd_q;
    h_m2r_d = h_m2r_q;  h_rw_d = h_rw_q;
    wb_pc_d = wb_pc_q;  wb_alu_d = wb_alu_q;  wb_rdata_d = wb_rdata_q;
    wb_rd_d = wb_rd_q;  wb_m2r_d = wb_m2r_q;  wb_rw_d = wb_rw_q;  wb_en_d = wb_en_q;
    mis_d = 1'b0;  berr_d = 1'b0;  err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (hazard_flush) begin
          wb_en_d = 1'b0;
          wb_rw_d = 1'b0;
        end else if (EX_MEM_enable_out && !mem_op) begin
          wb_pc_d = EX_MEM_PC;  wb_alu_d = EX_MEM_ALUResult;  wb_rd_d = EX_MEM_Rd;
          wb_m2r_d = EX_MEM_MemToReg;  wb_rw_d = EX_MEM_RegWrite;
          wb_rdata_d = '0;  wb_en_d = 1'b1;
        end else if (misaligned) begin
          wb_pc_d = EX_MEM_PC;  wb_alu_d = EX_MEM_ALUResult;  wb_rd_d = EX_MEM_Rd;
          wb_m2r_d = EX_MEM_MemToReg;  wb_rw_d = 1'b0;
          wb_rdata_d = '0;  wb_en_d = 1'b1;
          mis_d = 1'b1;  err_addr_d = EX_MEM_ALUResult;
        end else if (aligned_op) begin
          // Both MemRead and MemWrite set resolves to a store.
          req_d = 1'b1;  we_d = EX_MEM_MemWrite;
          addr_d = {EX_MEM_ALUResult[31:2], 2'b00};
          wdata_d = EX_MEM_WriteData;
          wstrb_d = EX_MEM_MemWrite ? 4'hF : 4'h0;
          cnt_d = '0;  squash_d = 1'b0;  wb_en_d = 1'b0;
          h_pc_d = EX_MEM_PC;  h_alu_d = EX_MEM_ALUResult;  h_rd_d = EX_MEM_Rd;
          h_m2r_d = EX_MEM_MemToReg;  h_rw_d = EX_MEM_RegWrite;
        end else begin
          wb_en_d = 1'b0;
        end
      end
      BUSY: begin
        squash_d = squash;
        if (done || abort) begin
          req_d = 1'b0;
          squash_d = 1'b0;
          if (squash) begin
            wb_en_d = 1'b0;
            wb_rw_d = 1'b0;
          end else begin
            wb_pc_d = h_pc_q;  wb_alu_d = h_alu_q;  wb_rd_d = h_rd_q;
            wb_m2r_d = h_m2r_q;  wb_en_d = 1'b1;
            wb_rdata_d = (done && !we_q) ? dmem.dmem_rdata : '0;
            wb_rw_d = done ? h_rw_q : 1'b0;
            if (abort) begin
              berr_d = 1'b1;
              err_addr_d = h_alu_q;
            end
          end
        end
        if (!done) cnt_d = cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;  wdata_q <= '0;  wstrb_q <= '0;
      cnt_q <= '0;  squash_q <= 1'b0;
      h_pc_q <= '0;  h_alu_q <= '0;  h_rd_q <= '0;  h_m2r_q <= 1'b0;  h_rw_q <= 1'b0;
      wb_pc_q <= '0;  wb_alu_q <= '0;  wb_rdata_q <= '0;  wb_rd_q <= '0;
      wb_m2r_q <= 1'b0;  wb_rw_q <= 1'b0;  wb_en_q <= 1'b0;
      mis_q <= 1'b0;  berr_q <= 1'b0;  err_addr_q <= '0;
    end else begin
      req_q <= req_d;  we_q <= we_d;  addr_q <= addr_d;  wdata_q <= wdata_d;  wstrb_q <= wstrb_d;
      cnt_q <= cnt_d;  squash_q <= squash_d;
      h_pc_q <= h_pc_d;  h_alu_q <= h_alu_d;  h_rd_q <= h_rd_d;  h_m2r_q <= h_m2r_d;  h_rw_q <= h_rw_d;
      wb_pc_q <= wb_pc_d;  wb_alu_q <= wb_alu_d;  wb_rdata_q <= wb_rdata_d;  wb_rd_q <= wb_rd_d;
      wb_m2r_q <= wb_m2r_d;  wb_rw_q <= wb_rw_d;  wb_en_q <= wb_en_d;
      mis_q <= mis_d;  berr_q <= berr_d;  err_addr_q <= err_addr_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

  assign MEM_WB_PC         = wb_pc_q;
  assign MEM_WB_ALUResult  = wb_alu_q;
  assign MEM_WB_ReadData   = wb_rdata_q;
  assign MEM_WB_Rd         = wb_rd_q;
  assign MEM_WB_MemToReg   = wb_m2r_q;
  assign MEM_WB_RegWrite   = wb_rw_q;
  assign MEM_WB_enable_out = wb_en_q;
  assign MEM_misaligned    = mis_q;
  assign MEM_bus_error     = berr_q;
  assign MEM_error_addr    = err_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with TIMEOUT_CYCLES=16.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hazard_flush;
  logic        EX_MEM_enable_out;
  logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite;
  logic        mem_stall_req;
  logic [31:0] MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData;
  logic [4:0]  MEM_WB_Rd;
  logic        MEM_WB_MemToReg, MEM_WB_RegWrite, MEM_WB_enable_out;
  logic        MEM_misaligned, MEM_bus_error;
  logic [31:0] MEM_error_addr;

  int errors = 0;
  int checks = 0;

  int          req_c, stall_c, mis_c, berr_c, unstable_c;
  logic        to_flag;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .hazard_flush      (hazard_flush),
    .EX_MEM_enable_out (EX_MEM_enable_out),
    .EX_MEM_PC         (EX_MEM_PC),
    .EX_MEM_ALUResult  (EX_MEM_ALUResult),
    .EX_MEM_WriteData  (EX_MEM_WriteData),
    .EX_MEM_Rd         (EX_MEM_Rd),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_MemWrite   (EX_MEM_MemWrite),
    .EX_MEM_MemToReg   (EX_MEM_MemToReg),
    .EX_MEM_RegWrite   (EX_MEM_RegWrite),
    .dmem              (dmem_bus),
    .mem_stall_req     (mem_stall_req),
    .MEM_WB_PC         (MEM_WB_PC),
    .MEM_WB_ALUResult  (MEM_WB_ALUResult),
    .MEM_WB_ReadData   (MEM_WB_ReadData),
    .MEM_WB_Rd         (MEM_WB_Rd),
    .MEM_WB_MemToReg   (MEM_WB_MemToReg),
    .MEM_WB_RegWrite   (MEM_WB_RegWrite),
    .MEM_WB_enable_out (MEM_WB_enable_out),
    .MEM_misaligned    (MEM_misaligned),
    .MEM_bus_error     (MEM_bus_error),
    .MEM_error_addr    (MEM_error_addr)
  );

  always #5 clk = ~clk;

  task automatic set_ex(input logic en, input logic rd_, input logic wr_, input logic m2r,
                        input logic rw, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd);
    EX_MEM_enable_out = en;  EX_MEM_MemRead = rd_;  EX_MEM_MemWrite = wr_;
    EX_MEM_MemToReg = m2r;  EX_MEM_RegWrite = rw;  EX_MEM_PC = pc;
    EX_MEM_ALUResult = alu;  EX_MEM_WriteData = wd;  EX_MEM_Rd = rd;
  endtask

  // Called at posedge+1 with an EX/MEM entry presented; acts as memory and hazard unit
  // (EX/MEM advances, here: goes invalid, after any edge where stall was low).
  task automatic run_busy(input int wait_n, input logic [31:0] rdata, input int flush_at);
    logic last_stall;
    req_c = 0;  stall_c = 0;  mis_c = 0;  berr_c = 0;  unstable_c = 0;  to_flag = 1'b0;
    #1;
    last_stall = mem_stall_req;
    if (last_stall) stall_c++;
    @(posedge clk); #1;
    if (!last_stall) EX_MEM_enable_out = 1'b0;
    mis_c += int'(MEM_misaligned);
    berr_c += int'(MEM_bus_error);
    for (int b = 1; b <= 300 && dmem_bus.dmem_req; b++) begin
      req_c++;
      if (b == 1) begin
        cap_addr = dmem_bus.dmem_addr;  cap_we = dmem_bus.dmem_we;
        cap_wdata = dmem_bus.dmem_wdata;  cap_wstrb = dmem_bus.dmem_wstrb;
      end else if (cap_addr !== dmem_bus.dmem_addr || cap_we !== dmem_bus.dmem_we ||
                   cap_wdata !== dmem_bus.dmem_wdata || cap_wstrb !== dmem_bus.dmem_wstrb) begin
        unstable_c++;
      end
      dmem_bus.dmem_ready = (b == wait_n + 1);
      dmem_bus.dmem_rdata = dmem_bus.dmem_ready ? rdata : 32'h0;
      hazard_flush = (b == flush_at);
      #1;
      last_stall = mem_stall_req;
      if (last_stall) stall_c++;
      @(posedge clk); #1;
      dmem_bus.dmem_ready = 1'b0;
      hazard_flush = 1'b0;
      if (!last_stall) EX_MEM_enable_out = 1'b0;
      mis_c += int'(MEM_misaligned);
      berr_c += int'(MEM_bus_error);
    end
    if (dmem_bus.dmem_req) to_flag = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_bus.dmem_req); end
    checks++; if (dmem_bus.dmem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %h expected 0", dmem_bus.dmem_wstrb); end
    checks++; if (MEM_WB_enable_out !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b expected 0", MEM_WB_enable_out); end
    checks++; if (MEM_WB_ALUResult !== 32'h0) begin errors++; $display("FAIL reset_wb_alu: got %h expected 0", MEM_WB_ALUResult); end
    checks++; if ({MEM_misaligned, MEM_bus_error} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {MEM_misaligned, MEM_bus_error}); end
    checks++; if (MEM_error_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr: got %h expected 0", MEM_error_addr); end
    checks++; if (mem_stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall_req); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0040, 32'h0, 5'd5);
    #1;
    checks++; if (mem_stall_req !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", mem_stall_req); end
    @(posedge clk); #1;
    checks++; if (MEM_WB_ALUResult !== 32'h40) begin errors++; $display("FAIL alu_result: got %h expected 00000040", MEM_WB_ALUResult); end
    checks++; if (MEM_WB_Rd !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d expected 5", MEM_WB_Rd); end
    checks++; if ({MEM_WB_enable_out, MEM_WB_RegWrite} !== 2'b11) begin errors++; $display("FAIL alu_en_rw: got %b expected 11", {MEM_WB_enable_out, MEM_WB_RegWrite}); end
    checks++; if (MEM_WB_PC !== 32'h1000) begin errors++; $display("FAIL alu_pc: got %h expected 00001000", MEM_WB_PC); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b expected 0", dmem_bus.dmem_req); end
    EX_MEM_enable_out = 1'b0;
    @(posedge clk); #1;
    checks++; if (MEM_WB_enable_out !== 1'b0) begin errors++; $display("FAIL bubble_en: got %b expected 0", MEM_WB_enable_out); end
    checks++; if (MEM_WB_ALUResult !== 32'h40) begin errors++; $display("FAIL bubble_hold: got %h expected 00000040", MEM_WB_ALUResult); end
  endtask

  task automatic test_load_wait;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1004, 32'h0000_0100, 32'h0, 5'd7);
    run_busy(3, 32'hDEAD_BEEF, 0);
    checks++; if (to_flag !== 1'b0) begin errors++; $display("FAIL load_bound: got req still high expected done"); end
    checks++; if (req_c !== 4) begin errors++; $display("FAIL load_req_cycles: got %0d expected 4", req_c); end
    checks++; if (stall_c !== 4) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 4", stall_c); end
    checks++; if (cap_addr !== 32'h100) begin errors++; $display("FAIL load_addr: got %h expected 00000100", cap_addr); end
    checks++; if ({cap_we, cap_wstrb} !== 5'b0_0000) begin errors++; $display("FAIL load_we_wstrb: got %b expected 00000", {cap_we, cap_wstrb}); end
    checks++; if (unstable_c !== 0) begin errors++; $display("FAIL load_bus_stable: got %0d changes expected 0", unstable_c); end
    checks++; if (MEM_WB_ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata: got %h expected deadbeef", MEM_WB_ReadData); end
    checks++; if ({MEM_WB_enable_out, MEM_WB_RegWrite, MEM_WB_MemToReg} !== 3'b111) begin errors++; $display("FAIL load_wb_ctl: got %b expected 111", {MEM_WB_enable_out, MEM_WB_RegWrite, MEM_WB_MemToReg}); end
    checks++; if (MEM_WB_Rd !== 5'd7) begin errors++; $display("FAIL load_rd: got %0d expected 7", MEM_WB_Rd); end
  endtask

  task automatic test_store;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1008, 32'h0000_0204, 32'h1234_5678, 5'd0);
    run_busy(0, 32'hFFFF_FFFF, 0);
    checks++; if (req_c !== 1) begin errors++; $display("FAIL store_req_cycles: got %0d expected 1", req_c); end
    checks++; if ({cap_we, cap_wstrb} !== 5'b1_1111) begin errors++; $display("FAIL store_we_wstrb: got %b expected 11111", {cap_we, cap_wstrb}); end
    checks++; if (cap_wdata !== 32'h1234_5678) begin errors++; $display("FAIL store_wdata: got %h expected 12345678", cap_wdata); end
    checks++; if (cap_addr !== 32'h204) begin errors++; $display("FAIL store_addr: got %h expected 00000204", cap_addr); end
    checks++; if (MEM_WB_ReadData !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h expected 0", MEM_WB_ReadData); end
    checks++; if (MEM_WB_enable_out !== 1'b1) begin errors++; $display("FAIL store_en: got %b expected 1", MEM_WB_enable_out); end
  endtask

  task automatic test_misaligned;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_100C, 32'h0000_0102, 32'h0, 5'd3);
    #1;
    checks++; if (mem_stall_req !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", mem_stall_req); end
    @(posedge clk); #1;
    EX_MEM_enable_out = 1'b0;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b expected 0", dmem_bus.dmem_req); end
    checks++; if (MEM_misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", MEM_misaligned); end
    checks++; if (MEM_error_addr !== 32'h102) begin errors++; $display("FAIL mis_err_addr: got %h expected 00000102", MEM_error_addr); end
    checks++; if ({MEM_WB_enable_out, MEM_WB_RegWrite} !== 2'b10) begin errors++; $display("FAIL mis_en_rw: got %b expected 10", {MEM_WB_enable_out, MEM_WB_RegWrite}); end
    @(posedge clk); #1;
    checks++; if (MEM_misaligned !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b expected 0", MEM_misaligned); end
    checks++; if (MEM_error_addr !== 32'h102) begin errors++; $display("FAIL mis_err_hold: got %h expected 00000102", MEM_error_addr); end
  endtask

  task automatic test_timeout;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1010, 32'h0000_0300, 32'h0, 5'd8);
    run_busy(1000, 32'h0, 0);
    checks++; if (req_c !== 16) begin errors++; $display("FAIL to_req_cycles: got %0d expected 16", req_c); end
    checks++; if (stall_c !== 16) begin errors++; $display("FAIL to_stall_cycles: got %0d expected 16", stall_c); end
    checks++; if (berr_c !== 1) begin errors++; $display("FAIL to_berr_pulse: got %0d expected 1", berr_c); end
    checks++; if ({MEM_WB_enable_out, MEM_WB_RegWrite} !== 2'b10) begin errors++; $display("FAIL to_en_rw: got %b expected 10", {MEM_WB_enable_out, MEM_WB_RegWrite}); end
    checks++; if (MEM_error_addr !== 32'h300) begin errors++; $display("FAIL to_err_addr: got %h expected 00000300", MEM_error_addr); end
    @(posedge clk); #1;
    checks++; if (MEM_bus_error !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", MEM_bus_error); end
  endtask

  task automatic test_back_to_back;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1014, 32'h0000_0500, 32'h0, 5'd10);
    run_busy(0, 32'h1111_1111, 0);
    checks++; if (MEM_WB_ReadData !== 32'h1111_1111) begin errors++; $display("FAIL b2b_rdata_a: got %h expected 11111111", MEM_WB_ReadData); end
    checks++; if (stall_c !== 1) begin errors++; $display("FAIL b2b_stall_a: got %0d expected 1", stall_c); end
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1018, 32'h0000_0504, 32'h0, 5'd11);
    run_busy(0, 32'h2222_2222, 0);
    checks++; if (req_c !== 1) begin errors++; $display("FAIL b2b_req_b: got %0d expected 1", req_c); end
    checks++; if (cap_addr !== 32'h504) begin errors++; $display("FAIL b2b_addr_b: got %h expected 00000504", cap_addr); end
    checks++; if (MEM_WB_ReadData !== 32'h2222_2222) begin errors++; $display("FAIL b2b_rdata_b: got %h expected 22222222", MEM_WB_ReadData); end
    checks++; if ({MEM_WB_Rd, MEM_WB_enable_out} !== {5'd11, 1'b1}) begin errors++; $display("FAIL b2b_rd_en_b: got %h expected %h", {MEM_WB_Rd, MEM_WB_enable_out}, {5'd11, 1'b1}); end
  endtask

  task automatic test_flush;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_101C, 32'h0000_0400, 32'h0, 5'd9);
    run_busy(3, 32'hCAFE_F00D, 2);
    checks++; if (req_c !== 4) begin errors++; $display("FAIL flush_req_held: got %0d expected 4", req_c); end
    checks++; if ({MEM_WB_enable_out, MEM_WB_RegWrite} !== 2'b00) begin errors++; $display("FAIL flush_discard: got %b expected 00", {MEM_WB_enable_out, MEM_WB_RegWrite}); end
    checks++; if (mis_c + berr_c !== 0) begin errors++; $display("FAIL flush_no_err: got %0d pulses expected 0", mis_c + berr_c); end
    hazard_flush = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1020, 32'h0000_0408, 32'h0, 5'd9);
    #1;
    checks++; if (mem_stall_req !== 1'b0) begin errors++; $display("FAIL idle_flush_stall: got %b expected 0", mem_stall_req); end
    @(posedge clk); #1;
    hazard_flush = 1'b0;
    EX_MEM_enable_out = 1'b0;
    checks++; if ({dmem_bus.dmem_req, MEM_WB_enable_out} !== 2'b00) begin errors++; $display("FAIL idle_flush_req_en: got %b expected 00", {dmem_bus.dmem_req, MEM_WB_enable_out}); end
  endtask

  task automatic test_reset_mid_busy;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1024, 32'h0000_0600, 32'h0, 5'd12);
    @(posedge clk); #1;
    checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req: got %b expected 1", dmem_bus.dmem_req); end
    #2;
    reset_n = 1'b0;
    EX_MEM_enable_out = 1'b0;
    #1;
    checks++; if ({dmem_bus.dmem_req, mem_stall_req, MEM_WB_enable_out} !== 3'b000) begin errors++; $display("FAIL rst_async: got %b expected 000", {dmem_bus.dmem_req, mem_stall_req, MEM_WB_enable_out}); end
    checks++; if (dmem_bus.dmem_addr !== 32'h0) begin errors++; $display("FAIL rst_async_addr: got %h expected 0", dmem_bus.dmem_addr); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({dmem_bus.dmem_req, mem_stall_req} !== 2'b00) begin errors++; $display("FAIL rst_no_pending: got %b expected 00", {dmem_bus.dmem_req, mem_stall_req}); end
  endtask

  initial begin
    reset_n = 1'b0;
    hazard_flush = 1'b0;
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_flush();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
